// File: rtl/rpn_pkg.sv
// Shared types and 7-segment constants for the RPN calculator result display.
// Segment order is {g,f,e,d,c,b,a}. A segment is lit when its bit is 0.
package rpn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHOW,
        SHOW_ERR
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'b1000000;
            4'd1:    digit_seg = 7'b1111001;
            4'd2:    digit_seg = 7'b0100100;
            4'd3:    digit_seg = 7'b0110000;
            4'd4:    digit_seg = 7'b0011001;
            4'd5:    digit_seg = 7'b0010010;
            4'd6:    digit_seg = 7'b0000010;
            4'd7:    digit_seg = 7'b1111000;
            4'd8:    digit_seg = 7'b0000000;
            4'd9:    digit_seg = 7'b0010000;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with a blanking input.
module seg7_decode
    import rpn_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : digit_seg(bcd);

endmodule

// File: rtl/rpn_result_display.sv
// RPN result display: valid/ready capture, sequential double-dabble, and HEX/LEDR drive.
// Define SIGNED_DISPLAY_EN to treat results as two's complement and show a sign on HEX5.
module rpn_result_display
    import rpn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NDIG   = 3
) (
    input  logic              CLOCK_50,
    input  logic              KEY1_n,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_err,
    input  logic              res_valid,
    output logic              res_ready,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5,
    output logic [9:0]        LEDR
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int BCD_W = 4 * NDIG;

    state_t            state;
    logic [DATA_W-1:0] bin_q;
    logic [DATA_W-1:0] raw_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              busy_q;
    logic [DATA_W-1:0] ledr_q;
    logic [6:0]        hex_q [6];

    logic [DATA_W-1:0] mag_in;
    logic              neg_in;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_shift;
    logic [NDIG-1:0]   blank;
    logic [6:0]        disp_seg [5];

`ifdef SIGNED_DISPLAY_EN
    // Magnitude stays DATA_W bits wide: the most negative value maps to 2**(DATA_W-1).
    assign neg_in = res_data[DATA_W-1];
    assign mag_in = neg_in ? (~res_data + DATA_W'(1)) : res_data;
`else
    assign neg_in = 1'b0;
    assign mag_in = res_data;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};

    // A digit is blanked when it and everything above it is zero; HEX0 always shows.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            seen     = seen | (bcd_q[4*i +: 4] != 4'd0);
            blank[i] = !seen && (i != 0);
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_digit
        if (g < NDIG) begin : g_used
            seg7_decode u_dec (
                .bcd   (bcd_q[4*g +: 4]),
                .blank (blank[g]),
                .seg   (disp_seg[g])
            );
        end else begin : g_unused
            assign disp_seg[g] = SEG_BLANK;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge KEY1_n) begin
        if (!KEY1_n) begin
            state     <= IDLE;
            res_ready <= 1'b1;
            bin_q     <= '0;
            raw_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            ledr_q    <= '0;
            // NOTE: hex_q is a plain register array, not a RAM, so it resets like any other flop.
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (res_valid && res_ready) begin
                        res_ready <= 1'b0;
                        if (res_err) begin
                            state <= SHOW_ERR;
                        end else begin
                            state  <= CONV;
                            busy_q <= 1'b1;
                            raw_q  <= res_data;
                            bin_q  <= mag_in;
                            neg_q  <= neg_in;
                            bcd_q  <= '0;
                            cnt_q  <= CNT_W'(DATA_W - 1);
                        end
                    end
                end
                CONV: begin
                    bcd_q <= bcd_shift;
                    bin_q <= {bin_q[DATA_W-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        state  <= SHOW;
                        busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                SHOW: begin
                    for (int i = 0; i < 5; i++) begin
                        hex_q[i] <= disp_seg[i];
                    end
                    hex_q[5]  <= neg_q ? SEG_MINUS : SEG_BLANK;
                    ledr_q    <= raw_q;
                    res_ready <= 1'b1;
                    state     <= IDLE;
                end
                SHOW_ERR: begin
                    for (int i = 0; i < 6; i++) begin
                        hex_q[i] <= SEG_BLANK;
                    end
                    hex_q[2]  <= SEG_E;
                    hex_q[1]  <= SEG_R;
                    hex_q[0]  <= SEG_R;
                    ledr_q    <= '0;
                    res_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

    always_comb begin
        LEDR              = '0;
        LEDR[DATA_W-1:0]  = ledr_q;
        LEDR[9]           = busy_q;
    end

endmodule

// File: tb/tb_rpn_result_display.sv
// Self-checking bench for rpn_result_display: vector table plus handshake, abort and sign sequences.
// Expected displays come from a decimal model; build with SIGNED_DISPLAY_EN to check the signed variant.
module tb_rpn_result_display;

    localparam int DW = 8;

    logic          CLOCK_50 = 1'b0;
    logic          KEY1_n   = 1'b0;
    logic [DW-1:0] res_data = '0;
    logic          res_err  = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [6:0]    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0]    LEDR;

    rpn_result_display #(.DATA_W(DW), .NDIG(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .KEY1_n    (KEY1_n),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5),
        .LEDR      (LEDR)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [5:0][6:0] hex;
        logic [9:0]      ledr;
    } disp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        disp_t         exp;
    } vec_t;

    int    n_checks = 0;
    int    n_errors = 0;
    disp_t sb[$];
    disp_t last_disp;
    vec_t  vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic disp_t blank_disp();
        disp_t e;
        for (int i = 0; i < 6; i++) e.hex[i] = 7'h7F;
        e.ledr = '0;
        return e;
    endfunction

    function automatic disp_t model(input logic [DW-1:0] d, input logic err);
        disp_t e;
        int    mag;
        int    p;
        logic  neg;
        e = blank_disp();
        if (err) begin
            e.hex[2] = 7'b0000110;
            e.hex[1] = 7'b0101111;
            e.hex[0] = 7'b0101111;
            return e;
        end
        neg = 1'b0;
        mag = int'(d);
`ifdef SIGNED_DISPLAY_EN
        if (d[DW-1]) begin
            neg = 1'b1;
            mag = 256 - int'(d);
        end
`endif
        e.ledr[DW-1:0] = d;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0 || mag >= p) e.hex[i] = seg_of((mag / p) % 10);
            p = p * 10;
        end
        e.hex[5] = neg ? 7'b0111111 : 7'h7F;
        return e;
    endfunction

    function automatic disp_t observe();
        disp_t o;
        o.hex  = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
        o.ledr = LEDR;
        return o;
    endfunction

    // Waits (bounded) for ready, transfers one word on the next rising edge and records its expectation.
    task automatic send(input logic [DW-1:0] d, input logic err);
        int waited;
        res_data  = d;
        res_err   = err;
        res_valid = 1'b1;
        waited    = 0;
        while (!res_ready && waited < 50) begin
            @(posedge CLOCK_50);
            #1;
            waited++;
        end
        if (!res_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_ready_timeout: ready stayed low for %0d cycles", waited);
        end else begin
            @(posedge CLOCK_50);
            sb.push_back(model(d, err));
        end
        #1;
        res_valid = 1'b0;
        res_err   = 1'b0;
    endtask

    // Counts edges from transfer until ready returns, checks the hold/busy window, then pops and compares.
    task automatic wait_done(input logic err, input string name);
        int    n;
        int    lat;
        disp_t got;
        disp_t e;
        lat = err ? 1 : DW + 1;
        n   = 0;
        while (n < 40) begin
            @(posedge CLOCK_50);
            #1;
            n++;
            if (n == 4 && !err) begin
                got = observe();
                check({name, "_hold_hex"}, 64'(got.hex), 64'(last_disp.hex));
                check({name, "_hold_ledr"}, 64'(got.ledr[DW-1:0]), 64'(last_disp.ledr[DW-1:0]));
                check({name, "_busy"}, 64'(LEDR[9]), 64'(1));
            end
            if (res_ready) break;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
        end else begin
            e   = sb.pop_front();
            got = observe();
            check({name, "_hex"}, 64'(got.hex), 64'(e.hex));
            check({name, "_ledr"}, 64'(got.ledr), 64'(e.ledr));
            last_disp = e;
        end
    endtask

    initial begin
        disp_t bd;
        int    n;

        vecs[0].data = 8'd255; vecs[0].err = 1'b0;
        vecs[1].data = 8'd0;   vecs[1].err = 1'b0;
        vecs[2].data = 8'hAA;  vecs[2].err = 1'b1;
        vecs[3].data = 8'd100; vecs[3].err = 1'b0;
        vecs[4].data = 8'd10;  vecs[4].err = 1'b0;
        vecs[5].data = 8'd99;  vecs[5].err = 1'b0;
        vecs[6].data = 8'd9;   vecs[6].err = 1'b0;
        vecs[7].data = 8'h80;  vecs[7].err = 1'b0;
        vecs[8].data = 8'h01;  vecs[8].err = 1'b0;
        vecs[9].data = 8'd127; vecs[9].err = 1'b0;
        for (int i = 0; i < 10; i++) vecs[i].exp = model(vecs[i].data, vecs[i].err);

        bd = blank_disp();
        last_disp = bd;

        // Reset state
        #25;
        check("reset_hex", 64'(observe().hex), 64'(bd.hex));
        check("reset_ledr", 64'(LEDR), 64'(0));
        check("reset_ready", 64'(res_ready), 64'(1));
        KEY1_n = 1'b1;
        #20;

        // First conversion with literal expectations
        send(8'd41, 1'b0);
        wait_done(1'b0, "t41");
        check("t41_hex1", 64'(HEX1), 64'(7'b0011001));
        check("t41_hex0", 64'(HEX0), 64'(7'b1111001));
        check("t41_hex2", 64'(HEX2), 64'(7'h7F));
        check("t41_ledr", 64'(LEDR), 64'(10'h029));
        check("t41_ready", 64'(res_ready), 64'(1));

        // Vector table
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].data, vecs[i].err);
            wait_done(vecs[i].err, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_table_hex", i), 64'(observe().hex), 64'(vecs[i].exp.hex));
        end

        // Back-to-back with valid held: 9 must wait for ready
        @(negedge CLOCK_50);
        res_data  = 8'd7;
        res_valid = 1'b1;
        @(posedge CLOCK_50);
        sb.push_back(model(8'd7, 1'b0));
        #1;
        res_data = 8'd9;
        n = 0;
        while (!res_ready && n < 40) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        check("b2b_ready_low_cycles", 64'(n), 64'(DW + 1));
        if (sb.size() != 0) begin
            disp_t e;
            e = sb.pop_front();
            check("b2b_first_hex", 64'(observe().hex), 64'(e.hex));
            last_disp = e;
        end
        @(posedge CLOCK_50);
        sb.push_back(model(8'd9, 1'b0));
        #1;
        res_valid = 1'b0;
        check("b2b_second_taken", 64'(res_ready), 64'(0));
        wait_done(1'b0, "b2b_second");
        check("b2b_hex0", 64'(HEX0), 64'(7'b0010000));

        // Reset mid-conversion
        send(8'd200, 1'b0);
        repeat (4) @(posedge CLOCK_50);
        #3;
        KEY1_n = 1'b0;
        #1;
        check("abort_hex", 64'(observe().hex), 64'(bd.hex));
        check("abort_ledr", 64'(LEDR), 64'(0));
        check("abort_ready", 64'(res_ready), 64'(1));
        sb.delete();
        last_disp = bd;
        #5;
        KEY1_n = 1'b1;
        send(8'd41, 1'b0);
        wait_done(1'b0, "after_abort");

        // Sign handling
        send(8'hFB, 1'b0);
        wait_done(1'b0, "tFB");
`ifdef SIGNED_DISPLAY_EN
        check("tFB_hex5", 64'(HEX5), 64'(7'b0111111));
        check("tFB_hex0", 64'(HEX0), 64'(7'b0010010));
        check("tFB_hex1", 64'(HEX1), 64'(7'h7F));
`else
        check("tFB_hex5", 64'(HEX5), 64'(7'h7F));
        check("tFB_hex2", 64'(HEX2), 64'(7'b0100100));
        check("tFB_hex0", 64'(HEX0), 64'(7'b1111001));
`endif
        check("tFB_ledr", 64'(LEDR), 64'(10'h0FB));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
